spectrum_peak_ranker: RTL
=========================

Name: spectrum_peak_ranker

Overview:
- Parametrised successor to the two-peak FFT power scanner in the signal-separation datapath.
- Consumes one frame of FFT power bins as a valid-qualified stream.
- Finds strict local maxima above a detection threshold inside a programmable bin window, and keeps the NPEAK strongest, sorted by power.
- Publishes bin, power, weak-component flags and error status once per frame to the waveform-classification logic.

Parameters:
PW, 64, power sample width (unsigned)
NFFT, 8192, bins per frame
BW, 13, bin index width, equal to clog2(NFFT)
NPEAK, 2, number of ranked peak slots (1..8)
SCAN_LO, 1, lowest bin eligible as peak
SCAN_HI, 4095, highest bin eligible as peak (SCAN_LO <= SCAN_HI <= NFFT-2)
DET_TH, 100000000000, minimum power for a peak (strictly greater)
WEAK_TH, 500000000000, power at or below which a reported peak is flagged weak
BIN_OFS, 0, subtracted from the raw index before reporting, saturating at 0

Ports:
sys_clk  in  1  clock
sys_rst_n  in  1  synchronous active-low reset
s_tvalid  in  1  power beat valid; no backpressure, every valid beat is accepted
s_tdata  in  PW  bin power
s_tlast  in  1  last bin of frame
peak_bin  out  NPEAK*BW  reported bins; slot 0 in LSBs, slot 0 is the strongest peak
peak_pow  out  NPEAK*PW  peak powers, same slot order
peak_vld  out  NPEAK  slot holds a peak
peak_weak  out  NPEAK  slot valid and power <= WEAK_TH
peak_cnt  out  8  peaks detected in the frame, saturating at 255
frame_done  out  1  one-cycle pulse when outputs update
frame_err  out  1  one-cycle pulse on frame length / tlast mismatch

Behaviour:
- Reset is synchronous and active-low on sys_rst_n. While reset is asserted, all outputs and internal state are 0. Reset mid-frame discards the partial frame; the next valid beat is index 0.
- Input handling:
  - An internal index counts valid beats from 0.
  - Gaps in s_tvalid freeze all state; results are independent of gap pattern.
- Peak test for bin i is evaluated once bin i+1 arrives. Bin i is a peak when all of the following hold:
  - P[i] > P[i-1]
  - P[i] >= P[i+1] (the first bin of a plateau wins)
  - P[i] > DET_TH
  - SCAN_LO <= i <= SCAN_HI
- Bins 0 and NFFT-1 are never peaks.
- Ranking:
  - Each peak is inserted into a sorted list of NPEAK entries, descending by power.
  - On equal power, the earlier (lower) bin keeps the higher rank.
  - When the list is full, a peak weaker than or equal to the last entry is dropped, but still counted in peak_cnt.
  - At most one insertion per cycle, with no stall.
- End of frame:
  - The beat at index NFFT-1 closes the frame.
  - Exactly 2 cycles after that beat is accepted: frame_done pulses and all outputs update in the same cycle.
  - Unused slots have vld=0, bin=0, pow=0, weak=0.
  - Outputs then hold until the next frame_done or reset.
- Errors:
  - s_tlast at an index < NFFT-1: frame_err pulses 2 cycles later, the frame is discarded, outputs are unchanged, no frame_done, and the index returns to 0.
  - No s_tlast at index NFFT-1: the frame is still published, and frame_err pulses in the same cycle as frame_done.
- Back-to-back frames: the first beat of the next frame may arrive the cycle after the closing beat. The new frame starts with an empty list and a zero count, and must not disturb the publication of the previous frame.
- Reported bin = raw index - BIN_OFS, or 0 if the raw index < BIN_OFS.

Test Plan (NFFT=16, BW=4, NPEAK=2, SCAN_LO=1, SCAN_HI=14, DET_TH=100, WEAK_TH=500, BIN_OFS=0 unless stated):
1. One peak: bin 5 = 1000, all other bins 0, continuous valid -> frame_done 2 cycles after the last beat; slot0 = bin 5, power 1000, vld=1, weak=0; slot1 vld=0; cnt=1.
2. Ranking with overflow: peaks at bins 3/7/11 with power 300/900/600 -> slot0 = bin 7 / 900, slot1 = bin 11 / 600, peak_weak = 00, cnt=3. Rerun with bin 7 = 400 -> slot0 = bin 11 / 600, slot1 = bin 7 / 400, peak_weak = 2'b10.
3. Ties, plateau and exclusions:
   - Bins 4 and 5 both 700 -> only bin 4 is a peak.
   - Equal 800 peaks at bins 2 and 9 -> slot0 = bin 2.
   - Bin 0 = 5000, bin 15 = 5000, bin 6 = 100 -> cnt=0.
   - SCAN_HI=8 with a peak at bin 10 -> ignored.
4. Framing errors:
   - s_tlast at index 9 -> frame_err pulse, no frame_done, outputs keep the prior frame.
   - A 16-beat frame without tlast -> frame_done and frame_err pulse in the same cycle.
5. Throughput: two frames back-to-back with random tvalid gaps in frame 2 -> each frame's results match the gap-free golden model; frame 2's count excludes frame 1's peaks.
6. Reset and offset:
   - sys_rst_n low for 1 cycle at index 8 -> all outputs 0; the next 16 beats form a clean frame.
   - BIN_OFS=3 with a peak at bin 2 -> reported bin 0.

Source files
------------

// File: rtl/spectrum_peak_ranker_if.sv
// -----------------------------------------------------------------------------
// spectrum_peak_ranker_if
//   Bundles the power-bin input stream and the per-frame peak report of
//   spectrum_peak_ranker.
//
//   Stream (producer -> ranker):
//     s_tvalid   power beat valid, no backpressure
//     s_tdata    bin power, PW bits unsigned
//     s_tlast    last bin of frame
//   Report (ranker -> consumer):
//     peak_bin   NPEAK*BW reported bins, slot 0 (strongest) in the LSBs
//     peak_pow   NPEAK*PW peak powers, same slot order
//     peak_vld   NPEAK slot-holds-a-peak flags
//     peak_weak  NPEAK weak-component flags
//     peak_cnt   peaks detected in the frame, saturating at 255
//     frame_done one-cycle pulse when the report updates
//     frame_err  one-cycle pulse on frame length / tlast mismatch
//
//   master: drives the stream and receives the report (testbench / upstream)
//   slave : consumes the stream and drives the report (the ranker)
// -----------------------------------------------------------------------------
interface spectrum_peak_ranker_if #(
    parameter int PW    = 64,
    parameter int BW    = 13,
    parameter int NPEAK = 2
);
    logic                  s_tvalid;
    logic [PW-1:0]         s_tdata;
    logic                  s_tlast;
    logic [NPEAK*BW-1:0]   peak_bin;
    logic [NPEAK*PW-1:0]   peak_pow;
    logic [NPEAK-1:0]      peak_vld;
    logic [NPEAK-1:0]      peak_weak;
    logic [7:0]            peak_cnt;
    logic                  frame_done;
    logic                  frame_err;

    modport master (
        output s_tvalid, s_tdata, s_tlast,
        input  peak_bin, peak_pow, peak_vld, peak_weak, peak_cnt,
               frame_done, frame_err
    );

    modport slave (
        input  s_tvalid, s_tdata, s_tlast,
        output peak_bin, peak_pow, peak_vld, peak_weak, peak_cnt,
               frame_done, frame_err
    );
endinterface

// File: rtl/spectrum_peak_ranker.sv
// -----------------------------------------------------------------------------
// spectrum_peak_ranker
//   Scans one frame of FFT power bins, finds strict local maxima above DET_TH
//   inside [SCAN_LO, SCAN_HI], and keeps the NPEAK strongest sorted by power
//   (descending, earlier bin wins ties). The ranked list is published once per
//   frame, two cycles after the closing beat.
//
//   Ports:
//     sys_clk    clock
//     sys_rst_n  synchronous active-low reset (clears all state and outputs)
//     bus        spectrum_peak_ranker_if.slave: input stream + peak report
// -----------------------------------------------------------------------------
module spectrum_peak_ranker #(
    parameter int          PW      = 64,
    parameter int          NFFT    = 8192,
    parameter int          BW      = 13,
    parameter int          NPEAK   = 2,
    parameter int          SCAN_LO = 1,
    parameter int          SCAN_HI = 4095,
    parameter logic [63:0] DET_TH  = 64'd100000000000,
    parameter logic [63:0] WEAK_TH = 64'd500000000000,
    parameter int          BIN_OFS = 0
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    spectrum_peak_ranker_if.slave bus
);

    localparam logic [BW-1:0] LAST_IDX = BW'(NFFT - 1);
    localparam logic [BW-1:0] LO_IDX   = BW'(SCAN_LO);
    localparam logic [BW-1:0] HI_IDX   = BW'(SCAN_HI);
    localparam logic [BW-1:0] OFS      = BW'(BIN_OFS);
    localparam logic [BW-1:0] ONE      = BW'(1);
    localparam logic [BW-1:0] TWO      = BW'(2);
    localparam logic [PW-1:0] DET_P    = PW'(DET_TH);
    localparam logic [PW-1:0] WEAK_P   = PW'(WEAK_TH);

    // Reported bin = raw - BIN_OFS, clamped at 0.
    function automatic logic [BW-1:0] sat_ofs(input logic [BW-1:0] raw);
        return (raw < OFS) ? '0 : raw - OFS;
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] c);
        return (c == 8'hFF) ? c : c + 8'd1;
    endfunction

    // Frame tracking: idx is the index the next valid beat will carry;
    // pow_cur / pow_prv hold P[idx-1] / P[idx-2].
    logic [BW-1:0] idx;
    logic [PW-1:0] pow_cur;
    logic [PW-1:0] pow_prv;

    logic          vld_p0;
    logic [BW-1:0] cand_bin_p0;
    logic [PW-1:0] cand_pow_p0;
    logic          close_p0;
    logic          short_p0;
    logic          nolast_p0;

    logic [PW-1:0]    lst_pow [NPEAK];
    logic [BW-1:0]    lst_bin [NPEAK];
    logic [NPEAK-1:0] lst_vld;
    logic [7:0]       cnt;

    logic [PW-1:0]    nxt_pow [NPEAK];
    logic [BW-1:0]    nxt_bin [NPEAK];
    logic [NPEAK-1:0] nxt_vld;
    logic [NPEAK-1:0] ge;

    logic [BW-1:0] bin_chk;
    logic          at_last;
    logic          is_peak;

    // The arriving beat is P[i+1]; it completes the test for bin i = idx-1.
    // idx >= 2 keeps bin 0 out; bin NFFT-1 is never tested because its
    // right neighbour never arrives.
    always_comb begin
        bin_chk = idx - ONE;
        at_last = (idx == LAST_IDX);
        is_peak = (idx >= TWO) &&
                  (bin_chk >= LO_IDX) && (bin_chk <= HI_IDX) &&
                  (pow_cur > pow_prv) &&
                  (pow_cur >= bus.s_tdata) &&
                  (pow_cur > DET_P);
    end

    // ---- stage p0: accept beat, register peak candidate and framing status
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            idx         <= '0;
            pow_cur     <= '0;
            pow_prv     <= '0;
            vld_p0      <= 1'b0;
            cand_bin_p0 <= '0;
            cand_pow_p0 <= '0;
            close_p0    <= 1'b0;
            short_p0    <= 1'b0;
            nolast_p0   <= 1'b0;
        end else if (bus.s_tvalid) begin
            vld_p0      <= is_peak;
            cand_bin_p0 <= sat_ofs(bin_chk);
            cand_pow_p0 <= pow_cur;
            close_p0    <= at_last;
            short_p0    <= bus.s_tlast && !at_last;
            nolast_p0   <= at_last && !bus.s_tlast;
            pow_prv     <= pow_cur;
            pow_cur     <= bus.s_tdata;
            idx         <= (at_last || bus.s_tlast) ? '0 : idx + ONE;
        end else begin
            vld_p0      <= 1'b0;
            close_p0    <= 1'b0;
            short_p0    <= 1'b0;
            nolast_p0   <= 1'b0;
        end
    end

    // Sorted insertion. ge[j] marks entries that outrank the candidate
    // (equal power included, since any stored entry has an earlier bin).
    // Valid entries are contiguous from slot 0, so ge is a prefix of ones:
    // the candidate lands at the first non-ge slot and everything below
    // shifts down one; a full list with all ge drops the candidate.
    // Invalid slots are all-zero, so shifting them keeps them all-zero.
    always_comb begin
        nxt_pow = lst_pow;
        nxt_bin = lst_bin;
        nxt_vld = lst_vld;
        for (int j = 0; j < NPEAK; j++) begin
            ge[j] = lst_vld[j] && (lst_pow[j] >= cand_pow_p0);
        end
        if (vld_p0 && !ge[0]) begin
            nxt_pow[0] = cand_pow_p0;
            nxt_bin[0] = cand_bin_p0;
            nxt_vld[0] = 1'b1;
        end
        for (int j = 1; j < NPEAK; j++) begin
            if (vld_p0 && !ge[j]) begin
                if (ge[j-1]) begin
                    nxt_pow[j] = cand_pow_p0;
                    nxt_bin[j] = cand_bin_p0;
                    nxt_vld[j] = 1'b1;
                end else begin
                    nxt_pow[j] = lst_pow[j-1];
                    nxt_bin[j] = lst_bin[j-1];
                    nxt_vld[j] = lst_vld[j-1];
                end
            end
        end
    end

    // ---- stage p1: insert candidate, publish on frame close, handle errors
    // The closing beat's candidate is merged and published in the same edge,
    // and the list is emptied so a back-to-back frame starts clean.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            for (int j = 0; j < NPEAK; j++) begin
                lst_pow[j] <= '0;
                lst_bin[j] <= '0;
            end
            lst_vld        <= '0;
            cnt            <= '0;
            bus.peak_bin   <= '0;
            bus.peak_pow   <= '0;
            bus.peak_vld   <= '0;
            bus.peak_weak  <= '0;
            bus.peak_cnt   <= '0;
            bus.frame_done <= 1'b0;
            bus.frame_err  <= 1'b0;
        end else begin
            bus.frame_done <= 1'b0;
            bus.frame_err  <= 1'b0;
            if (short_p0 || close_p0) begin
                for (int j = 0; j < NPEAK; j++) begin
                    lst_pow[j] <= '0;
                    lst_bin[j] <= '0;
                end
                lst_vld <= '0;
                cnt     <= '0;
            end else begin
                lst_pow <= nxt_pow;
                lst_bin <= nxt_bin;
                lst_vld <= nxt_vld;
                if (vld_p0) begin
                    cnt <= sat_inc(cnt);
                end
            end
            if (short_p0) begin
                bus.frame_err <= 1'b1;
            end else if (close_p0) begin
                bus.frame_done <= 1'b1;
                bus.frame_err  <= nolast_p0;
                bus.peak_cnt   <= vld_p0 ? sat_inc(cnt) : cnt;
                bus.peak_vld   <= nxt_vld;
                for (int j = 0; j < NPEAK; j++) begin
                    bus.peak_bin[j*BW +: BW] <= nxt_bin[j];
                    bus.peak_pow[j*PW +: PW] <= nxt_pow[j];
                    bus.peak_weak[j]         <= nxt_vld[j] && (nxt_pow[j] <= WEAK_P);
                end
            end
        end
    end

endmodule
